// File: rtl/markov_note_generator_pkg.sv
// markov_note_generator_pkg: table geometry, field extractors and FSM states shared with the merge stage
package markov_note_generator_pkg;
  localparam int NOTE_BIT_LEN     = 7;
  localparam int DELAY_BIT_LEN    = 8;
  localparam int SEQUENCE_LEN     = 3;
  localparam int SEQ_CNT_BIT_LEN  = 8;
  localparam int MARKOV_CHAIN_LEN = 16;
  localparam int ENTRIES = 2 * MARKOV_CHAIN_LEN;
  localparam int PAIR_W  = NOTE_BIT_LEN + DELAY_BIT_LEN;
  localparam int KEY_W   = (SEQUENCE_LEN - 1) * PAIR_W;
  localparam int ENTRY_W = SEQUENCE_LEN * PAIR_W + SEQ_CNT_BIT_LEN;
  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int SUM_W   = SEQ_CNT_BIT_LEN + IDX_W;
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  typedef logic [ENTRY_W-1:0]         entry_t;
  typedef logic [PAIR_W-1:0]          pair_t;
  typedef logic [KEY_W-1:0]           key_t;
  typedef logic [SEQ_CNT_BIT_LEN-1:0] cnt_t;

  typedef enum logic [2:0] {IDLE, SEED, SUM, PICK, SELECT, EMIT, FINISH} state_e;

  function automatic cnt_t entry_count(input entry_t e);
    return e[SEQ_CNT_BIT_LEN-1:0];
  endfunction

  function automatic key_t entry_key(input entry_t e);
    return e[SEQ_CNT_BIT_LEN +: KEY_W];
  endfunction

  function automatic pair_t entry_succ(input entry_t e);
    return e[SEQ_CNT_BIT_LEN+KEY_W +: PAIR_W];
  endfunction

  // Oldest pair sits in the low bits, so dropping it is a right shift with the new pair on top.
  function automatic key_t hist_shift(input key_t h, input pair_t s);
    return KEY_W'({s, h} >> PAIR_W);
  endfunction
endpackage

// File: rtl/markov_note_generator_lfsr16.sv
// markov_lfsr16: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) with zero-seed substitution
module markov_lfsr16
  import markov_note_generator_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [15:0] seed,
  output logic [15:0] nxt
);
  logic [15:0] lfsr_q;

  assign nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge clk or negedge reset)
    if (!reset) lfsr_q <= LFSR_INIT;
    else if (load) lfsr_q <= (seed == '0) ? LFSR_INIT : seed;
    else if (advance) lfsr_q <= nxt;
endmodule

// File: rtl/markov_note_generator.sv
// markov_note_generator: weighted random walk over a merged Markov chain table, one note per handshake
module markov_note_generator
  import markov_note_generator_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [15:0]                 seed,
  input  logic [15:0]                 num_notes,
  input  logic [ENTRIES*ENTRY_W-1:0]  markov,
  output logic [NOTE_BIT_LEN-1:0]     note_out,
  output logic [DELAY_BIT_LEN-1:0]    delay_out,
  output logic                        note_valid,
  input  logic                        note_ready,
  output logic                        dead_end,
  output logic                        busy,
  output logic                        done
);
  state_e             state_q, state_d;
  key_t               hist_q, hist_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SUM_W-1:0]   total_q, total_d, acc_q, acc_d, r_q, r_d;
  logic [15:0]        rem_q, rem_d, lfsr_nxt;
  pair_t              out_q, out_d;
  logic               valid_q, valid_d, dead_q, dead_d;
  entry_t             ent;
  logic               hit;
  logic [SUM_W-1:0]   tot_n, acc_n, r_n;

  markov_lfsr16 u_lfsr (
    .clk(clk), .reset(reset), .load(state_q == IDLE && start),
    .advance(state_q == PICK), .seed(seed), .nxt(lfsr_nxt)
  );

  assign ent   = markov[int'(idx_q)*ENTRY_W +: ENTRY_W];
  assign hit   = entry_count(ent) != '0 && entry_key(ent) == hist_q;
  assign tot_n = total_q + (hit ? SUM_W'(entry_count(ent)) : '0);
  assign acc_n = acc_q + (hit ? SUM_W'(entry_count(ent)) : '0);
  // Scaling the LFSR draw by total keeps r strictly below total.
  assign r_n   = SUM_W'(({{SUM_W{1'b0}}, lfsr_nxt} * {16'b0, total_q}) >> 16);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    idx_d   = idx_q;
    total_d = total_q;
    acc_d   = acc_q;
    r_d     = r_q;
    rem_d   = rem_q;
    out_d   = out_q;
    valid_d = valid_q;
    dead_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        rem_d   = num_notes;
        state_d = SEED;
      end
      SEED: begin
        hist_d  = entry_key(markov[ENTRY_W-1:0]);
        idx_d   = '0;
        total_d = '0;
        state_d = (entry_count(markov[ENTRY_W-1:0]) == '0 || rem_q == '0) ? FINISH : SUM;
      end
      SUM: begin
        total_d = tot_n;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(ENTRIES-1)) begin
          dead_d  = tot_n == '0;
          state_d = (tot_n == '0) ? SEED : PICK;
        end
      end
      PICK: begin
        r_d     = r_n;
        idx_d   = '0;
        acc_d   = '0;
        state_d = SELECT;
      end
      SELECT: begin
        acc_d = acc_n;
        idx_d = idx_q + 1'b1;
        if (hit && acc_n > r_q) begin
          out_d   = entry_succ(ent);
          valid_d = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: if (note_ready) begin
        valid_d = 1'b0;
        hist_d  = hist_shift(hist_q, out_q);
        rem_d   = rem_q - 16'd1;
        idx_d   = '0;
        total_d = '0;
        state_d = (rem_q == 16'd1) ? FINISH : SUM;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      hist_q  <= '0;
      idx_q   <= '0;
      total_q <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      idx_q   <= idx_d;
      total_q <= total_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      dead_q  <= dead_d;
    end

  assign note_out   = out_q[PAIR_W-1:DELAY_BIT_LEN];
  assign delay_out  = out_q[DELAY_BIT_LEN-1:0];
  assign note_valid = valid_q;
  assign dead_end   = dead_q;
  assign busy       = state_q != IDLE && state_q != FINISH;
  assign done       = state_q == FINISH;
endmodule

// File: tb/tb_markov_note_generator.sv
// tb_markov_note_generator: scoreboard bench, directed walks checked note by note
module tb_markov_note_generator;
  import markov_note_generator_pkg::*;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, note_ready = 1'b1;
  logic [15:0] seed = '0, num_notes = '0;
  logic [ENTRIES*ENTRY_W-1:0] markov = '0;
  logic [NOTE_BIT_LEN-1:0] note_out;
  logic [DELAY_BIT_LEN-1:0] delay_out;
  logic note_valid, dead_end, busy, done;

  int checks = 0, passes = 0, done_cnt = 0, dead_cnt = 0;
  pair_t exp_q[$], got[$], run1[$];
  localparam pair_t A = {7'd60, 8'd10};
  localparam pair_t B = {7'd62, 8'd20};
  localparam pair_t C = {7'd64, 8'd30};

  always #5 clk = ~clk;

  markov_note_generator dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .num_notes(num_notes),
    .markov(markov), .note_out(note_out), .delay_out(delay_out), .note_valid(note_valid),
    .note_ready(note_ready), .dead_end(dead_end), .busy(busy), .done(done)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  always @(negedge clk) if (reset) begin
    if (done) done_cnt++;
    if (dead_end) dead_cnt++;
    if (note_valid && note_ready) begin
      chk("note_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("note", 32'({note_out, delay_out}), 32'(exp_q.pop_front()));
      got.push_back({note_out, delay_out});
    end
  end

  task automatic put(input int i, input pair_t p0, input pair_t p1, input pair_t p2, input cnt_t c);
    markov[i*ENTRY_W +: ENTRY_W] = {p2, p1, p0, c};
  endtask

  task automatic cycle_table();
    markov = '0;
    put(0, A, B, C, 8'd1);
    put(1, B, C, A, 8'd1);
    put(2, C, A, B, 8'd1);
  endtask

  task automatic pulse_start(input logic [15:0] s, input logic [15:0] n);
    seed = s;
    num_notes = n;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done(input string n, input int budget);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < budget && done_cnt == d0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    chk({n, "_done"}, 32'(done_cnt - d0), 32'd1);
    chk({n, "_busy"}, 32'(busy), 32'd0);
    chk({n, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Expected stream for the weighting table: only history (A,A) branches, on the top quarter of the draw.
  task automatic model(input logic [15:0] s, input int n);
    logic [15:0] x;
    logic fb;
    int h;
    x = s;
    h = 0;
    for (int i = 0; i < n; i++) begin
      fb = x[0];
      x = x >> 1;
      if (fb) x = x ^ 16'b1011_0100_0000_0000;
      if (h == 0 && x[15:14] == 2'b11) begin
        exp_q.push_back(B);
        h = 1;
      end else begin
        exp_q.push_back(A);
        h = (h == 1) ? 2 : 0;
      end
    end
  endtask

  initial begin
    int d, k, aa, tot, diffs;
    pair_t held, p1, p2;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_note", 32'(note_out), 32'd0);
    chk("rst_delay", 32'(delay_out), 32'd0);
    chk("rst_valid", 32'(note_valid), 32'd0);
    chk("rst_dead", 32'(dead_end), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;

    // Deterministic cycle, with an ignored start while busy
    cycle_table();
    exp_q.push_back(C); exp_q.push_back(A); exp_q.push_back(B); exp_q.push_back(C); exp_q.push_back(A);
    d = dead_cnt;
    pulse_start(16'h0001, 16'd5);
    repeat (4) @(posedge clk);
    #2 num_notes = 16'd1; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_done("cycle", 1000);
    chk("cycle_dead", 32'(dead_cnt - d), 32'd0);

    // num_notes = 0: done exactly two cycles after start
    seed = 16'h0003;
    num_notes = 16'd0;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    chk("nn0_busy", 32'(busy), 32'd1);
    chk("nn0_early", 32'(done), 32'd0);
    @(posedge clk); #2;
    chk("nn0_done", 32'(done), 32'd1);
    @(posedge clk); #2;
    chk("nn0_pulse", 32'(done), 32'd0);
    chk("nn0_idle", 32'(busy), 32'd0);

    // Backpressure
    note_ready = 1'b0;
    exp_q.push_back(C); exp_q.push_back(A); exp_q.push_back(B);
    pulse_start(16'h0007, 16'd3);
    k = 0;
    while (k < 200 && !note_valid) begin
      @(posedge clk); #2;
      k++;
    end
    chk("bp_valid", 32'(note_valid), 32'd1);
    held = {note_out, delay_out};
    repeat (10) begin
      @(posedge clk); #2;
      chk("bp_hold_valid", 32'(note_valid), 32'd1);
      chk("bp_hold_data", 32'({note_out, delay_out}), 32'(held));
    end
    note_ready = 1'b1;
    wait_done("bp", 1000);

    // Dead end: history (B,C) never matches, walk reseeds from entry 0
    markov = '0;
    put(0, A, B, C, 8'd1);
    exp_q.push_back(C); exp_q.push_back(C); exp_q.push_back(C);
    d = dead_cnt;
    pulse_start(16'h0005, 16'd3);
    wait_done("dead", 2000);
    chk("dead_pulses", 32'(dead_cnt - d), 32'd2);

    // Entry 0 empty
    markov = '0;
    d = dead_cnt;
    pulse_start(16'h0005, 16'd5);
    wait_done("empty", 200);
    chk("empty_dead", 32'(dead_cnt - d), 32'd0);

    // Reset during SELECT (SEED + 32 SUM + PICK cycles after start)
    cycle_table();
    pulse_start(16'h0009, 16'd5);
    repeat (34) @(posedge clk);
    #2;
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(note_valid), 32'd0);
    chk("mid_rst_note", 32'({note_out, delay_out}), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    d = done_cnt;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (5) @(posedge clk);
    chk("mid_no_done", 32'(done_cnt - d), 32'd0);
    exp_q.push_back(C); exp_q.push_back(A);
    pulse_start(16'h0009, 16'd2);
    wait_done("after_rst", 500);

    // Weighting 3:1 from history (A,A), then a rerun with the same seed
    markov = '0;
    put(0, A, A, A, 8'd3);
    put(1, A, A, B, 8'd1);
    put(2, A, B, A, 8'd1);
    put(3, B, A, A, 8'd1);
    model(16'h1234, 500);
    got.delete();
    pulse_start(16'h1234, 16'd500);
    wait_done("weight1", 25000);
    run1 = got;
    aa = 0; tot = 0; p1 = A; p2 = A;
    foreach (got[i]) begin
      if (p1 == A && p2 == A) begin
        tot++;
        if (got[i] == A) aa++;
      end
      p1 = p2;
      p2 = got[i];
    end
    $display("A,A -> A transitions: %0d of %0d", aa, tot);
    chk("ratio", 32'(tot > 0 && aa * 100 >= tot * 65 && aa * 100 <= tot * 85), 32'd1);
    model(16'h1234, 500);
    got.delete();
    pulse_start(16'h1234, 16'd500);
    wait_done("weight2", 25000);
    chk("rerun_len", 32'(got.size()), 32'(run1.size()));
    diffs = 0;
    foreach (got[i]) if (i < run1.size() && got[i] != run1[i]) diffs++;
    chk("rerun_diff", 32'(diffs), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
